// File: rtl/vga_tile_pkg.sv
// Shared types and constants for the multi-tile VGA address generator.
package vga_tile_pkg;

    typedef logic [2:0] colour_t;

    localparam colour_t BLANK_COLOUR  = 3'b000;
    localparam colour_t BORDER_COLOUR = 3'b111;

    localparam int unsigned TILE_IDX_W = 3;

    // First address past all tiles; the framebuffer keeps this region zero-filled.
    function automatic int unsigned blank_addr(input int unsigned num_tiles,
                                               input int unsigned tile_w,
                                               input int unsigned tile_h);
        return num_tiles * tile_w * tile_h;
    endfunction

endpackage

// File: rtl/vga_tile_hit.sv
// Inclusive range compare and local column offset for a single tile.
module vga_tile_hit #(
    parameter int unsigned TILE       = 0,
    parameter int unsigned TILE_W     = 150,
    parameter int unsigned TILE_H     = 150,
    parameter int unsigned COL0       = 50,
    parameter int unsigned ROW0       = 200,
    parameter int unsigned TILE_PITCH = 200,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 9
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           hit_c,
    output logic [X_W-1:0] dx_c
);

    localparam int unsigned XORG = COL0 + TILE * TILE_PITCH;
    localparam int unsigned XEND = XORG + TILE_W - 1;
    localparam int unsigned YEND = ROW0 + TILE_H - 1;

    always_comb begin
        hit_c = (32'(x) >= XORG) && (32'(x) <= XEND) &&
                (32'(y) >= ROW0) && (32'(y) <= YEND);
        dx_c  = X_W'(32'(x) - XORG);
    end

endmodule

// File: rtl/vga_tile_address_gen.sv
// Maps VGA scan position onto a linear framebuffer address for a row of tiles, 2-cycle pipeline.
// Optional feature: define VGA_TILE_BORDER_EN to draw a 1-pixel white ring around each tile.
module vga_tile_address_gen
    import vga_tile_pkg::*;
#(
    parameter int unsigned NUM_TILES   = 3,
    parameter int unsigned TILE_W      = 150,
    parameter int unsigned TILE_H      = 150,
    parameter int unsigned COL0        = 50,
    parameter int unsigned ROW0        = 200,
    parameter int unsigned TILE_PITCH  = 200,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 9,
    parameter int unsigned ADDR_W      = 17,
    parameter logic [3*NUM_TILES-1:0] COLOUR_INIT = 9'b011_010_110
) (
    input  logic              clock25,
    input  logic              reset_n,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic              pixel_valid,
    input  logic              frame_start,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_tile,
    input  logic [2:0]        cfg_colour,
    output logic [ADDR_W-1:0] mem_address,
    output logic [2:0]        colour,
    output logic              image_on,
    output logic [2:0]        tile_idx,
    output logic              out_valid
);

    localparam int unsigned TILE_SIZE  = TILE_W * TILE_H;
    localparam int unsigned BLANK_ADDR = blank_addr(NUM_TILES, TILE_W, TILE_H);
    localparam int unsigned PROD_W     = Y_W + $clog2(TILE_W);
    localparam int unsigned CFG_W      = 3 * NUM_TILES;

    if (NUM_TILES < 1 || NUM_TILES > 8 || TILE_PITCH < TILE_W ||
        BLANK_ADDR >= (1 << ADDR_W)) begin : g_bad_params
        $error("vga_tile_address_gen: illegal parameter set");
    end

    logic [NUM_TILES-1:0]  hit_vec_c;
    logic [X_W-1:0]        dx_arr_c [NUM_TILES];
    logic [TILE_IDX_W-1:0] tile_c;
    logic [X_W-1:0]        dx_c;
    logic [Y_W-1:0]        dy_c;

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        vga_tile_hit #(
            .TILE(t), .TILE_W(TILE_W), .TILE_H(TILE_H), .COL0(COL0), .ROW0(ROW0),
            .TILE_PITCH(TILE_PITCH), .X_W(X_W), .Y_W(Y_W)
        ) u_hit (
            .x(x), .y(y), .hit_c(hit_vec_c[t]), .dx_c(dx_arr_c[t])
        );
    end

    // Priority encoder: lowest tile index wins.
    always_comb begin
        tile_c = '0;
        dx_c   = '0;
        for (int t = int'(NUM_TILES) - 1; t >= 0; t--) begin
            if (hit_vec_c[t]) begin
                tile_c = TILE_IDX_W'(t);
                dx_c   = dx_arr_c[t];
            end
        end
        dy_c = Y_W'(32'(y) - ROW0);
    end

    logic [NUM_TILES-1:0]  hit_vec_q;
    logic [X_W-1:0]        dx_q;
    logic [Y_W-1:0]        dy_q;
    logic [TILE_IDX_W-1:0] tile_q;
    logic                  valid_q;

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            hit_vec_q <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            tile_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            hit_vec_q <= pixel_valid ? hit_vec_c : '0;
            dx_q      <= dx_c;
            dy_q      <= dy_c;
            tile_q    <= tile_c;
            valid_q   <= pixel_valid;
        end
    end

    logic [CFG_W-1:0] shadow_q, active_q;
    logic [CFG_W-1:0] shadow_next, active_next;

    // A write landing with frame_start goes straight through to active.
    always_comb begin
        shadow_next = shadow_q;
        for (int t = 0; t < int'(NUM_TILES); t++) begin
            if (cfg_we && cfg_tile == TILE_IDX_W'(t)) begin
                shadow_next[3*t +: 3] = cfg_colour;
            end
        end
        active_next = frame_start ? shadow_next : active_q;
    end

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= COLOUR_INIT;
            active_q <= COLOUR_INIT;
        end else begin
            shadow_q <= shadow_next;
            active_q <= active_next;
        end
    end

    logic [PROD_W-1:0] prod_c;
    logic [ADDR_W-1:0] addr_c;
    colour_t           colour_sel_c;
    logic              any_hit_c;

    // Colour reads the next active value so a frame_start applies to the very next output.
    always_comb begin
        prod_c       = PROD_W'(dy_q) * PROD_W'(TILE_W);
        addr_c       = ADDR_W'(tile_q) * ADDR_W'(TILE_SIZE) + ADDR_W'(dx_q) + ADDR_W'(prod_c);
        any_hit_c    = |hit_vec_q;
        colour_sel_c = BLANK_COLOUR;
        for (int t = 0; t < int'(NUM_TILES); t++) begin
            if (tile_q == TILE_IDX_W'(t)) begin
                colour_sel_c = active_next[3*t +: 3];
            end
        end
`ifdef VGA_TILE_BORDER_EN
        if (dx_q == '0 || dx_q == X_W'(TILE_W - 1) || dy_q == '0 || dy_q == Y_W'(TILE_H - 1)) begin
            addr_c       = ADDR_W'(BLANK_ADDR);
            colour_sel_c = BORDER_COLOUR;
        end
`endif
    end

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            mem_address <= ADDR_W'(BLANK_ADDR);
            colour      <= BLANK_COLOUR;
            image_on    <= 1'b0;
            tile_idx    <= '0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= valid_q;
            if (any_hit_c) begin
                mem_address <= addr_c;
                colour      <= colour_sel_c;
                image_on    <= 1'b1;
                tile_idx    <= tile_q;
            end else begin
                mem_address <= ADDR_W'(BLANK_ADDR);
                colour      <= BLANK_COLOUR;
                image_on    <= 1'b0;
                tile_idx    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_address_gen.sv
// Randomised and directed bench for vga_tile_address_gen against a behavioural reference.
module tb_vga_tile_address_gen;

    localparam int NT = 3, TW = 150, TH = 150, C0 = 50, R0 = 200, PITCH = 200;
    localparam int TS = TW * TH;
    localparam int BLANK = NT * TS;

    typedef struct packed {
        logic [16:0] addr;
        logic [2:0]  col;
        logic        on;
        logic [2:0]  idx;
        logic        ov;
    } exp_t;

    logic        clock25 = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_tile = '0;
    logic [2:0]  cfg_colour = '0;
    logic [16:0] mem_address;
    logic [2:0]  colour;
    logic        image_on;
    logic [2:0]  tile_idx;
    logic        out_valid;

    int n_checks = 0;
    int n_err    = 0;

    vga_tile_address_gen dut (
        .clock25(clock25), .reset_n(reset_n), .x(x), .y(y), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .cfg_we(cfg_we), .cfg_tile(cfg_tile), .cfg_colour(cfg_colour),
        .mem_address(mem_address), .colour(colour), .image_on(image_on), .tile_idx(tile_idx),
        .out_valid(out_valid)
    );

    always #20 clock25 = ~clock25;

    function automatic exp_t blank_exp(input logic ov);
        exp_t e;
        e.addr = 17'(BLANK);
        e.col  = 3'b000;
        e.on   = 1'b0;
        e.idx  = 3'd0;
        e.ov   = ov;
        return e;
    endfunction

    // Output for one pixel, straight from the tile geometry rules.
    function automatic exp_t model(input int px, input int py, input logic pv,
                                   input logic [2:0] act [NT]);
        exp_t e;
        e = blank_exp(pv);
        if (pv) begin
            for (int t = 0; t < NT; t++) begin
                int xo;
                xo = C0 + t * PITCH;
                if (py >= R0 && py <= R0 + TH - 1 && px >= xo && px <= xo + TW - 1 && !e.on) begin
                    e.on   = 1'b1;
                    e.idx  = 3'(t);
                    e.addr = 17'(t * TS + (px - xo) + (py - R0) * TW);
                    e.col  = act[t];
`ifdef VGA_TILE_BORDER_EN
                    if (px == xo || px == xo + TW - 1 || py == R0 || py == R0 + TH - 1) begin
                        e.addr = 17'(BLANK);
                        e.col  = 3'b111;
                    end
`endif
                end
            end
        end
        return e;
    endfunction

    logic [2:0] m_shadow [NT];
    logic [2:0] m_active [NT];
    int         p_x, p_y;
    logic       p_v;
    exp_t       exp_q;

    task automatic model_reset();
        m_shadow[0] = 3'b110; m_shadow[1] = 3'b010; m_shadow[2] = 3'b011;
        m_active = m_shadow;
        p_x = 0; p_y = 0; p_v = 1'b0;
        exp_q = blank_exp(1'b0);
    endtask

    // Reference timeline: config updates on each edge, outputs follow the pixel taken one edge earlier.
    always @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            if (cfg_we && int'(cfg_tile) < NT) m_shadow[cfg_tile] = cfg_colour;
            if (frame_start) m_active = m_shadow;
            exp_q = model(p_x, p_y, p_v, m_active);
            p_x = int'(x);
            p_y = int'(y);
            p_v = pixel_valid;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clock25) begin
        check("cyc mem_address", 32'(mem_address), 32'(exp_q.addr));
        check("cyc colour",      32'(colour),      32'(exp_q.col));
        check("cyc image_on",    32'(image_on),    32'(exp_q.on));
        check("cyc tile_idx",    32'(tile_idx),    32'(exp_q.idx));
        check("cyc out_valid",   32'(out_valid),   32'(exp_q.ov));
    end

    task automatic step();
        @(posedge clock25);
        #2;
    endtask

    // Present one pixel (optionally with a config action) and check the output two edges later.
    task automatic lit(input string nm, input int px, input int py,
                       input logic we, input logic [2:0] ct, input logic [2:0] cc, input logic fs,
                       input int ea, input logic [2:0] ec, input logic eo, input logic [2:0] ei);
        x = 10'(px); y = 9'(py); pixel_valid = 1'b1;
        cfg_we = we; cfg_tile = ct; cfg_colour = cc; frame_start = fs;
        @(posedge clock25);
        #2;
        cfg_we = 1'b0; frame_start = 1'b0;
        @(posedge clock25);
        @(negedge clock25);
        check({nm, " addr"},   32'(mem_address), 32'(ea));
        check({nm, " colour"}, 32'(colour),      32'(ec));
        check({nm, " on"},     32'(image_on),    32'(eo));
        check({nm, " idx"},    32'(tile_idx),    32'(ei));
        check({nm, " valid"},  32'(out_valid),   32'd1);
        step();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock25);
        check("reset addr",  32'(mem_address), 32'h107AC);
        check("reset valid", 32'(out_valid),   32'd0);
        check("reset on",    32'(image_on),    32'd0);
        step();
        reset_n = 1'b1;
        step();

`ifdef VGA_TILE_BORDER_EN
        lit("border corner",   50, 200, 0, 0, 0, 0, 'h107AC, 3'b111, 1, 0);
        lit("border interior", 51, 201, 0, 0, 0, 0, 151,     3'b110, 1, 0);
`else
        lit("origin t0",  50, 200, 0, 0, 0, 0, 0,     3'b110, 1, 0);
        lit("corner t0", 199, 349, 0, 0, 0, 0, 22499, 3'b110, 1, 0);
        lit("origin t1", 250, 200, 0, 0, 0, 0, 22500, 3'b010, 1, 1);
        lit("corner t2", 599, 349, 0, 0, 0, 0, 67499, 3'b011, 1, 2);
`endif
        lit("gap",       200, 250, 0, 0, 0, 0, 'h107AC, 3'b000, 0, 0);
        lit("row 199",   100, 199, 0, 0, 0, 0, 'h107AC, 3'b000, 0, 0);
        lit("row 350",   100, 350, 0, 0, 0, 0, 'h107AC, 3'b000, 0, 0);

        // Shadow write without frame_start leaves the displayed colour alone.
        cfg_we = 1'b1; cfg_tile = 3'd1; cfg_colour = 3'b101;
        step();
        cfg_we = 1'b0;
        lit("pre commit",  260, 210, 0, 0, 0, 0, 24010, 3'b010, 1, 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        lit("post commit", 260, 210, 0, 0, 0, 0, 24010, 3'b101, 1, 1);
        lit("same cycle",  460, 210, 1, 2, 3'b001, 1, 46510, 3'b001, 1, 2);
        lit("bad tile t0",  60, 210, 1, 5, 3'b111, 1, 1510,  3'b110, 1, 0);
        lit("bad tile t1", 260, 210, 0, 0, 0, 0, 24010, 3'b101, 1, 1);

        // Streaming with a one-cycle reset pulse.
        y = 9'd200; pixel_valid = 1'b1;
        x = 10'd50; step();
        x = 10'd51; step();
        x = 10'd52; reset_n = 1'b0;
        #1;
        check("async rst valid", 32'(out_valid),   32'd0);
        check("async rst addr",  32'(mem_address), 32'h107AC);
        check("async rst on",    32'(image_on),    32'd0);
        step();
        x = 10'd53; reset_n = 1'b1; step();
        for (int i = 54; i < 60; i++) begin
            x = 10'(i);
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            x           = 10'($urandom_range(0, 700));
            y           = 9'($urandom_range(150, 400));
            pixel_valid = ($urandom_range(0, 9) != 0);
            cfg_we      = ($urandom_range(0, 19) == 0);
            cfg_tile    = 3'($urandom_range(0, 7));
            cfg_colour  = 3'($urandom);
            frame_start = ($urandom_range(0, 49) == 0);
            step();
        end
        cfg_we = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
